// File: rtl/fnd_scan_ctrl.sv
// rtl/fnd_scan_ctrl.sv - APB slave that BCD-converts a value and scans a 4-digit FND
module fnd_scan_ctrl #(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic [7:0]  fnd_data,
  output logic [3:0]  fnd_com
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] BLANK_V  = SW'(BLANK_CYC);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [2:0]  fcr;
  logic [15:0] fdr;
  logic [3:0]  fpr;
  logic        wr_en, wr_fcr, wr_fdr, wr_fpr, launch;
  logic [2:0]  fcr_next;
  logic [15:0] fdr_next;

  state_t      state, state_nx;
  logic [4:0]  cnt, cnt_nx;
  logic [19:0] bcd, bcd_nx, adj;
  logic [15:0] bin, bin_nx;
  logic [15:0] digits, digits_nx;
  logic [35:0] shifted;

  logic [TW-1:0] tick;
  logic [SW-1:0] slot;
  logic [1:0]    idx;

  logic        unused;
  assign unused = ^{PADDR[1:0], PWDATA[31:16]};

  assign PREADY = 1'b1;

  assign wr_en    = PSEL & PENABLE & PWRITE;
  assign wr_fcr   = wr_en && (PADDR[3:2] == 2'd0);
  assign wr_fdr   = wr_en && (PADDR[3:2] == 2'd1);
  assign wr_fpr   = wr_en && (PADDR[3:2] == 2'd2);
  assign launch   = wr_fcr | wr_fdr;
  // A launch must see the value being written in the same edge, not the old register.
  assign fcr_next = wr_fcr ? PWDATA[2:0]  : fcr;
  assign fdr_next = wr_fdr ? PWDATA[15:0] : fdr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fcr <= 3'd0;
      fdr <= 16'd0;
      fpr <= 4'd0;
    end else begin
      fcr <= fcr_next;
      fdr <= fdr_next;
      if (wr_fpr) fpr <= PWDATA[3:0];
    end
  end

  always_comb begin
    PRDATA = 32'd0;
    if (PSEL && !PWRITE) begin
      case (PADDR[3:2])
        2'd0:    PRDATA = {29'd0, fcr};
        2'd1:    PRDATA = {16'd0, fdr};
        2'd2:    PRDATA = {28'd0, fpr};
        default: PRDATA = {31'd0, state == SHIFT};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      bcd    <= 20'd0;
      bin    <= 16'd0;
      digits <= 16'd0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      bcd    <= bcd_nx;
      bin    <= bin_nx;
      digits <= digits_nx;
    end
  end

  always_comb begin
    adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    shifted = {adj, bin} << 1;

    state_nx  = state;
    cnt_nx    = cnt;
    bcd_nx    = bcd;
    bin_nx    = bin;
    digits_nx = digits;

    if (state == SHIFT) begin
      bcd_nx = shifted[35:16];
      bin_nx = shifted[15:0];
      cnt_nx = cnt + 5'd1;
      // Only the finished result reaches the display; ten-thousands nibble dropped.
      if (cnt == 5'd15) begin
        digits_nx = shifted[31:16];
        state_nx  = IDLE;
      end
    end

    if (launch) begin
      if (fcr_next[1]) begin
        digits_nx = fdr_next;
        state_nx  = IDLE;
      end else begin
        bcd_nx   = 20'd0;
        bin_nx   = fdr_next;
        cnt_nx   = 5'd0;
        state_nx = SHIFT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick <= '0;
      slot <= '0;
      idx  <= 2'd0;
    end else if (tick == TICK_MAX) begin
      tick <= '0;
      slot <= '0;
      idx  <= idx + 2'd1;
    end else begin
      tick <= tick + 1'b1;
      if (slot < BLANK_V) slot <= slot + 1'b1;
    end
  end

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 8'hC0;  4'h1: seg7 = 8'hF9;  4'h2: seg7 = 8'hA4;  4'h3: seg7 = 8'hB0;
      4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h92;  4'h6: seg7 = 8'h82;  4'h7: seg7 = 8'hF8;
      4'h8: seg7 = 8'h80;  4'h9: seg7 = 8'h90;  4'hA: seg7 = 8'h88;  4'hB: seg7 = 8'h83;
      4'hC: seg7 = 8'hC6;  4'hD: seg7 = 8'hA1;  4'hE: seg7 = 8'h86;  default: seg7 = 8'h8E;
    endcase
  endfunction

  logic [3:0] cur;
  logic [3:0] lz;
  logic [7:0] seg;

  always_comb begin
    cur   = digits[idx*4 +: 4];
    // lz[i]: digit i and everything above it is zero; digit 0 is always shown.
    lz[3] = (digits[15:12] == 4'd0);
    lz[2] = lz[3] && (digits[11:8] == 4'd0);
    lz[1] = lz[2] && (digits[7:4] == 4'd0);
    lz[0] = 1'b0;

    if (fcr[2] && lz[idx])          seg = 8'hFF;
    else if (!fcr[1] && cur > 4'd9) seg = 8'hFF;
    else                            seg = seg7(cur);

    if (!fcr[0]) begin
      fnd_data = 8'hFF;
      fnd_com  = 4'b1111;
    end else begin
      fnd_data = {seg[7] & ~fpr[idx], seg[6:0]};
      fnd_com  = (slot < BLANK_V) ? 4'b1111 : ~(4'b0001 << idx);
    end
  end

endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

APB-slave controller that owns the 4-digit FND and sequences it for the CPU. Software writes a control word, a 16-bit value and a decimal-point mask. The block then does three things: converts the value to BCD with a sequential double-dabble engine, latches the display digits glitch-free, and time-multiplexes the digits with a blanking gap between slots. It sits on the APB bus beside the other slaves and drives the board's `fnd_data`/`fnd_com` pins directly.

## Interface
- `TICK_DIV`, 100000: clk cycles per digit slot (1 kHz at 100 MHz).
- `BLANK_CYC`, 1000: clk cycles at the start of each slot with all commons off (anti-ghosting). Must be < `TICK_DIV`.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `PADDR` in 4: byte address; only [3:2] are decoded.
- `PSEL` in 1: slave select.
- `PENABLE` in 1: APB access phase.
- `PWRITE` in 1: 1 = write.
- `PWDATA` in 32: write data.
- `PRDATA` out 32: read data.
- `PREADY` out 1: tied to 1 (zero wait states).
- `fnd_data` out 8: segments, active-low; bit7 = dp, [6:0] = g..a.
- `fnd_com` out 4: digit commons, active-low one-hot; bit0 = ones digit.

## Operation
- Registers, addressed by PADDR[3:2]:
  - 0 FCR (R/W), bits [2:0]: bit0 EN, bit1 MODE (0 decimal, 1 hex), bit2 LZB (leading-zero blank).
  - 1 FDR (R/W), bits [15:0]: display value.
  - 2 FPR (R/W), bits [3:0]: dp mask, bit i lights the dp of digit i.
  - 3 FSR (RO), bit0: BUSY.
  - Unused bits read as 0.
- APB access:
  - A write commits on the clk edge where PSEL & PENABLE & PWRITE is high.
  - PRDATA is combinational while PSEL & !PWRITE, and 0 otherwise.
  - Writes to FSR are ignored.
- Conversion FSM:
  - States IDLE and SHIFT; a 5-bit shift counter.
  - A convert is launched by an FDR write or an FCR write, whichever occurs.
  - On launch in decimal mode: load a 20-bit BCD register with 0 and a 16-bit shift register with FDR, then go to SHIFT.
  - Each SHIFT cycle: add 3 to every BCD nibble that is ≥ 5, then shift {bcd, bin} left by 1.
  - After the 16th shift, latch the low four BCD nibbles into the display-digit register and return to IDLE. The ten-thousands nibble is discarded, so the display shows value mod 10000.
  - On launch in hex mode: latch FDR[15:0] nibbles into the display digits in the same edge. The FSM stays IDLE.
  - A launch while in SHIFT aborts the current conversion and restarts it with the new value. The last write wins.
  - BUSY = (state == SHIFT).
- Scan:
  - A tick counter counts 0..TICK_DIV-1. On wrap, the 2-bit digit index increments 0→1→2→3→0.
  - A slot counter restarts on every index change.
  - While the slot counter < BLANK_CYC, `fnd_com` = 4'b1111. Otherwise `fnd_com` = ~(1 << index).
- Segment decode of the selected digit:
  - 0–9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90.
  - A–F: 88, 83, C6, A1, 86, 8E.
  - A decimal-mode digit > 9 decodes to FF.
  - bit7 is forced to 0 when FPR[index] = 1.
- LZB = 1: a digit is blanked to 8'hFF (dp still applied) when it and every higher digit are 0. Digit 0 is never blanked.
- EN = 0: `fnd_com` = 4'b1111 and `fnd_data` = 8'hFF. The scan counters and the FSM keep running.

## Timing
- Reset values:
  - FCR = FDR = FPR = 0.
  - FSM IDLE; digits 0; tick, slot and index counters 0.
  - `fnd_com` = 4'b1111, `fnd_data` = 8'hFF, `PRDATA` = 0, `PREADY` = 1.
- Decimal conversion latency:
  - A write at edge N sets BUSY high from N+1.
  - Shifts occur at edges N+1..N+16. The digits update, and BUSY falls, at edge N+16.
  - The display never shows a partial BCD result.
- Hex latency: digits update at edge N; BUSY stays 0.
- A FSR read in the cycle after a decimal FDR write returns 1.
- Index change: at the edge where the tick counter wraps; `fnd_com` goes to 1111 that same cycle.
- Outputs are combinational from registered state only: no input-to-output path except APB→PRDATA.
- Reset mid-conversion: the FSM returns to IDLE and the digits are cleared immediately (asynchronous).

## Test plan
- Reset, then EN=1, decimal, FDR=1234 → BUSY high for 16 cycles; then digits 4,3,2,1 → `fnd_data` 99, B0, A4, F9 on `fnd_com` 1110, 1101, 1011, 0111.
- FDR=65535, decimal → display 5535, i.e. digit3 = 5 (92). Then FDR=0x00AB, hex → digits B, A, 0, 0 with no BUSY.
- LZB=1, decimal, FDR=7, FPR=4'b0100 → digit0 = F8; digits 1 and 3 = FF; digit2 = 7F (blank, dp lit).
- FDR=1111, then FDR=2222 three cycles later → the restart completes 16 cycles after the second write; 1111 is never displayed.
- TICK_DIV=20, BLANK_CYC=4 → each slot shows 4 cycles of 1111 then 16 cycles of the one-hot common, and the index wraps 3→0. EN=0 → constant 1111/FF.
- Assert reset (low) during SHIFT → BUSY, digits and outputs return to their reset values before the next clk edge.
